main_fsm: RTL and testbench

Moore state machine that sequences the multi-cycle processor through fetch, decode, memory, execute, writeback and branch steps. It sits in the controller directly upstream of the conditional-write logic. It supplies the unconditioned write requests (NextPC, RegW, MemW, Branch) that the condition check gates, and it drives all datapath multiplexer and enable selects. Instruction decode fields arrive from the instruction register, which holds them stable from DECODE until the next FETCH.

---
 rtl/main_fsm_pkg.sv | 35 +++
 rtl/ff_res.sv | 16 +
 rtl/main_fsm.sv | 127 ++++++++++++
 tb/tb_main_fsm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared controller definitions: state codes, datapath mux encodings and
// instruction class codes used by main_fsm, the decoder and the condition logic.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;
    localparam logic [1:0] OP_ILL     = 2'b11;

endpackage

// File: rtl/ff_res.sv
// Generic register with asynchronous active-high reset to zero.
module ff_res #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle processor main controller: Moore FSM sequencing fetch through
// writeback and driving datapath selects plus unconditioned write requests.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | read registers, classify instruction
// MEMADR   | compute memory address
// MEMRD    | read data memory
// MEMWB    | write load data to register file
// MEMWR    | write data memory
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | branch request, target from ALU
// UNKNOWN  | illegal instruction, halted until reset
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Halt,
    output logic [3:0] State
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       unused_funct;

    assign unused_funct = ^Funct[4:1];

    // FETCH is code 0, so the reset-to-zero register lands in FETCH.
    ff_res #(.WIDTH(4)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_q)
    );

    always_comb begin
        state_d = S_UNKNOWN;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWR,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_UNKNOWN;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Halt      = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                NextPC    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMRD:    AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                Branch    = 1'b1;
            end
            default:    Halt = 1'b1;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: per-instruction expected state/output
// sequences are queued by the stimulus and popped by a negedge monitor.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Halt;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .Halt      (Halt),
        .State     (State)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ALUOp, NextPC, RegW, MemW, Branch, Halt};

    int          total  = 0;
    int          passed = 0;
    bit          mon_en = 1'b0;
    logic [17:0] expq[$];
    int          seq[$];

    // Output table for each state, written straight from the state descriptions.
    function automatic logic [13:0] exp_out(int s);
        logic       irw = 0, adr = 0, aop = 0, npc = 0, rw = 0, mw = 0, br = 0, hlt = 0;
        logic [1:0] sa = 0, sb = 0, rs = 0;
        case (s)
            0:  begin irw = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; npc = 1; end
            1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            2:  sb = 2'b01;
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  aop = 1;
            7:  begin sb = 2'b01; aop = 1; end
            8:  rw = 1;
            9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            default: hlt = 1;
        endcase
        return {irw, adr, sa, sb, rs, aop, npc, rw, mw, br, hlt};
    endfunction

    function automatic logic [17:0] exp_vec(int s);
        return {4'(s), exp_out(s)};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                      name, act[17:14], act[13:0], exp[17:14], exp[13:0]);
    endtask

    // Instruction-level model: the state walk each instruction class takes.
    task automatic build_seq(input logic [1:0] op, input logic [5:0] f);
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            2'b01: if (f[0]) begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
                   else      begin seq.push_back(2); seq.push_back(5); end
            2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
            2'b10: seq.push_back(9);
            default: for (int i = 0; i < 20; i++) seq.push_back(10);
        endcase
    endtask

    // Entered at posedge+2 of a FETCH cycle; for legal ops, returns at
    // posedge+2 of the following FETCH cycle. Inputs are garbage in cycles
    // where the decode fields must be ignored.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f);
        int len;
        build_seq(op, f);
        foreach (seq[i]) expq.push_back(exp_vec(seq[i]));
        len = seq.size();
        Op    = 2'($urandom);
        Funct = 6'($urandom);
        for (int k = 1; k < len; k++) begin
            @(posedge clk); #2;
            if (k == len - 1 || (op == 2'b11 && k >= 2)) begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end else begin
                Op    = op;
                Funct = f;
            end
        end
        if (op != 2'b11) begin
            @(posedge clk); #2;
        end else begin
            @(negedge clk); #1;
        end
    endtask

    task automatic do_reset_from_halt();
        mon_en = 1'b0;
        check("halt_before_reset", obs, exp_vec(10));
        reset = 1'b1;
        #1;
        check("reset_from_halt_async", obs, exp_vec(0));
        @(posedge clk); #2;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic do_instr(input logic [1:0] op, input logic [5:0] f);
        run_instr(op, f);
        if (op == 2'b11) do_reset_from_halt();
    endtask

    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL monitor_underflow: got state=%0d, expected no output cycle", State);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("cycle_state%0d", e[17:14]), obs, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [1:0] op;
        logic [5:0] f;
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;
        #1;
        check("reset_async", obs, exp_vec(0));
        @(posedge clk); #2;
        check("reset_hold", obs, exp_vec(0));
        reset  = 1'b0;
        mon_en = 1'b1;

        do_instr(2'b01, 6'b000001);
        do_instr(2'b01, 6'b000000);
        do_instr(2'b00, 6'b101000);
        do_instr(2'b00, 6'b001000);
        do_instr(2'b10, 6'b010110);

        // Abort a store while MemW is asserted.
        mon_en = 1'b0;
        Op     = 2'b01;
        Funct  = 6'b000000;
        repeat (3) begin @(posedge clk); #2; end
        check("pre_abort_memwr", obs, exp_vec(5));
        reset = 1'b1;
        #1;
        check("abort_async_fetch", obs, exp_vec(0));
        @(posedge clk); #2;
        check("abort_reset_hold", obs, exp_vec(0));
        reset  = 1'b0;
        mon_en = 1'b1;
        do_instr(2'b00, 6'b001000);

        do_instr(2'b11, 6'b000000);
        do_instr(2'b01, 6'b100001);

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            do_instr(op, f);
        end

        mon_en = 1'b0;
        total++;
        if (expq.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", expq.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
